reg_file_2w2r: RTL and testbench

- Parametrised successor to the CPU's 8x8 register file.
- Provides two write ports and two read ports.
- Write commits are stalled by memory BUSYWAIT; same-address write collisions are detected and reported.
- Sits in the datapath between decode and ALU and feeds operand A/B. Sized so a dual-issue or writeback-plus-load path can share one file.

---
 rtl/reg_file_2w2r.sv | 137 +++++++++++++
 tb/tb_reg_file_2w2r.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2w2r.sv
// ---------------------------------------------------------------------------
// reg_file_2w2r
//   Parametrised two-write / two-read register file. It feeds operand A/B
//   between decode and the ALU. It is sized so that two writers can share
//   one file, for example dual issue, or a writeback path plus a load path.
//
//   Parameters
//     DATA_W    register width
//     ADDR_W    address width (depth = 2**ADDR_W)
//     ZERO_REG  1: register 0 reads as zero and ignores writes
//     CNT_W     width of the committed-write counter (wraps)
//
//   Ports
//     CLK          clock, rising edge
//     RESET        asynchronous active-low reset
//     BUSYWAIT     memory stall; blocks all write commits
//     WRITE1/2     write enables
//     INADDRESS1/2 write addresses
//     IN1/2        write data
//     OUT1ADDRESS  read address A
//     OUT2ADDRESS  read address B
//     OUT1/OUT2    combinational read data A/B
//     COLLISION    registered one-cycle pulse after a same-address dual write
//     WRITE_COUNT  registered count of registers actually updated
//
//   Optional build macro
//     REGFILE_BYPASS_EN  write-first forwarding from the committing write
//                        data to the read ports (port 2 has priority)
// ---------------------------------------------------------------------------
module reg_file_2w2r #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic              WRITE1,
  input  logic [ADDR_W-1:0] INADDRESS1,
  input  logic [DATA_W-1:0] IN1,
  input  logic              WRITE2,
  input  logic [ADDR_W-1:0] INADDRESS2,
  input  logic [DATA_W-1:0] IN2,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              COLLISION,
  output logic [CNT_W-1:0]  WRITE_COUNT
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_collision;
  logic [CNT_W-1:0]  r_count;

  logic              w_same_addr;
  logic              w_collision;
  logic              w_commit1;
  logic              w_commit2;
  logic              w_commit1_eff;
  logic [CNT_W-1:0]  w_inc;

  // True when the address is the hardwired-zero register.
  function automatic logic f_is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign w_same_addr = (INADDRESS1 == INADDRESS2);

  // The collision flag is computed before the zero-register filter, so a
  // dual write to register 0 still raises it.
  assign w_collision = WRITE1 & WRITE2 & ~BUSYWAIT & w_same_addr;

  assign w_commit1 = WRITE1 & ~BUSYWAIT & ~f_is_zero_reg(INADDRESS1);
  assign w_commit2 = WRITE2 & ~BUSYWAIT & ~f_is_zero_reg(INADDRESS2);

  // Port 2 wins a same-address collision, so port 1's commit is dropped.
  // As a result a collision updates only one register.
  assign w_commit1_eff = w_commit1 & ~(w_commit2 & w_same_addr);

  assign w_inc = CNT_W'(w_commit1_eff) + CNT_W'(w_commit2);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_collision <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_commit1_eff) begin
        r_mem[INADDRESS1] <= IN1;
      end
      if (w_commit2) begin
        r_mem[INADDRESS2] <= IN2;
      end
      r_collision <= w_collision;
      r_count     <= r_count + w_inc;
    end
  end

  // Read ports
  always_comb begin
    OUT1 = r_mem[OUT1ADDRESS];
`ifdef REGFILE_BYPASS_EN
    if (w_commit2 && (OUT1ADDRESS == INADDRESS2)) begin
      OUT1 = IN2;
    end else if (w_commit1 && (OUT1ADDRESS == INADDRESS1)) begin
      OUT1 = IN1;
    end
`endif
    if (f_is_zero_reg(OUT1ADDRESS)) begin
      OUT1 = '0;
    end
  end

  always_comb begin
    OUT2 = r_mem[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
    if (w_commit2 && (OUT2ADDRESS == INADDRESS2)) begin
      OUT2 = IN2;
    end else if (w_commit1 && (OUT2ADDRESS == INADDRESS1)) begin
      OUT2 = IN1;
    end
`endif
    if (f_is_zero_reg(OUT2ADDRESS)) begin
      OUT2 = '0;
    end
  end

  assign COLLISION   = r_collision;
  assign WRITE_COUNT = r_count;

endmodule

// File: tb/tb_reg_file_2w2r.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2w2r
//   Directed bench for reg_file_2w2r. Instance A uses the default parameters.
//   Instance B uses ZERO_REG=1 and CNT_W=2. Inputs change 1 ns after the
//   rising edge, and outputs are sampled 1 ns after the edge or later.
// ---------------------------------------------------------------------------
module tb_reg_file_2w2r;

  logic       CLK;
  logic       RESET;

  // Instance A (defaults)
  logic       a_busy, a_w1, a_w2;
  logic [2:0] a_ad1, a_ad2, a_ra, a_rb;
  logic [7:0] a_d1, a_d2;
  logic [7:0] a_o1, a_o2;
  logic       a_col;
  logic [15:0] a_cnt;

  // Instance B (ZERO_REG=1, CNT_W=2)
  logic       b_busy, b_w1, b_w2;
  logic [2:0] b_ad1, b_ad2, b_ra, b_rb;
  logic [7:0] b_d1, b_d2;
  logic [7:0] b_o1, b_o2;
  logic       b_col;
  logic [1:0] b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_2w2r u_a (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(a_busy),
    .WRITE1(a_w1), .INADDRESS1(a_ad1), .IN1(a_d1),
    .WRITE2(a_w2), .INADDRESS2(a_ad2), .IN2(a_d2),
    .OUT1ADDRESS(a_ra), .OUT2ADDRESS(a_rb),
    .OUT1(a_o1), .OUT2(a_o2), .COLLISION(a_col), .WRITE_COUNT(a_cnt)
  );

  reg_file_2w2r #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .CNT_W(2)) u_b (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(b_busy),
    .WRITE1(b_w1), .INADDRESS1(b_ad1), .IN1(b_d1),
    .WRITE2(b_w2), .INADDRESS2(b_ad2), .IN2(b_d2),
    .OUT1ADDRESS(b_ra), .OUT2ADDRESS(b_rb),
    .OUT1(b_o1), .OUT2(b_o2), .COLLISION(b_col), .WRITE_COUNT(b_cnt)
  );

  // Rising edges at 10, 20, 30 ns ...
  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    a_busy = 0; a_w1 = 0; a_w2 = 0; a_ad1 = 0; a_ad2 = 0; a_d1 = 0; a_d2 = 0;
    a_ra = 0; a_rb = 0;
    b_busy = 0; b_w1 = 0; b_w2 = 0; b_ad1 = 0; b_ad2 = 0; b_d1 = 0; b_d2 = 0;
    b_ra = 0; b_rb = 0;

    // Reset state
    #2;
    chk("rst_a_out1", a_o1, 0);
    chk("rst_a_col", a_col, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_cnt", b_cnt, 0);
    #3 RESET = 1'b1;

    // Fill registers 0..7 with their own index through port 1
    for (int i = 0; i < 8; i++) begin
      a_w1 = 1; a_ad1 = 3'(i); a_d1 = 8'(i); a_ra = 3'(i);
      if (i == 7) begin
        #1 chk("no_fwd_a_pre_edge", a_o1, 0);
      end
      tick();
      chk($sformatf("fill_reg%0d", i), a_o1, i);
    end
    a_w1 = 0;
    chk("fill_cnt", a_cnt, 8);

    // Dual write to different addresses
    a_w1 = 1; a_ad1 = 2; a_d1 = 8'h11;
    a_w2 = 1; a_ad2 = 5; a_d2 = 8'h22;
    a_ra = 2; a_rb = 5;
    tick();
    a_w1 = 0; a_w2 = 0;
    chk("dual_out1", a_o1, 8'h11);
    chk("dual_out2", a_o2, 8'h22);
    chk("dual_cnt", a_cnt, 10);
    chk("dual_col", a_col, 0);

    // Same-address collision: port 2 wins
    a_w1 = 1; a_ad1 = 3; a_d1 = 8'hAA;
    a_w2 = 1; a_ad2 = 3; a_d2 = 8'h55;
    a_ra = 3;
    tick();
    a_w1 = 0; a_w2 = 0;
    chk("col_data", a_o1, 8'h55);
    chk("col_flag", a_col, 1);
    chk("col_cnt", a_cnt, 11);
    tick();
    chk("col_flag_clear", a_col, 0);
    chk("col_cnt_hold", a_cnt, 11);

    // Stall: BUSYWAIT blocks commits and collision detection
    a_busy = 1;
    a_w1 = 1; a_ad1 = 4; a_d1 = 8'hFF;
    a_w2 = 1; a_ad2 = 4; a_d2 = 8'h99;
    a_ra = 4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_reg4_%0d", k), a_o1, 4);
      chk($sformatf("stall_cnt_%0d", k), a_cnt, 11);
      chk($sformatf("stall_col_%0d", k), a_col, 0);
    end
    a_busy = 0; a_w2 = 0;
    tick();
    a_w1 = 0;
    chk("stall_release_reg4", a_o1, 8'hFF);
    chk("stall_release_cnt", a_cnt, 12);

    // Asynchronous reset between edges, with COLLISION pending
    a_w1 = 1; a_ad1 = 6; a_d1 = 8'h01;
    a_w2 = 1; a_ad2 = 6; a_d2 = 8'h02;
    tick();
    a_w1 = 0; a_w2 = 0;
    chk("pre_areset_col", a_col, 1);
    a_ra = 4; a_rb = 5;
    #2 RESET = 1'b0;
    #1;
    chk("areset_out1", a_o1, 0);
    chk("areset_out2", a_o2, 0);
    chk("areset_col", a_col, 0);
    chk("areset_cnt", a_cnt, 0);
    // A write presented while reset is held is lost
    a_w1 = 1; a_ad1 = 1; a_d1 = 8'h77; a_ra = 1;
    tick();
    a_w1 = 0;
    chk("write_in_reset_lost", a_o1, 0);
    chk("write_in_reset_cnt", a_cnt, 0);
    #2 RESET = 1'b1;
    tick();
    chk("post_reset_reg1", a_o1, 0);

    // Instance B: register 0 is hardwired to zero
    b_w1 = 1; b_ad1 = 0; b_d1 = 8'h7F; b_ra = 0;
    #1 chk("b_zero_pre_edge", b_o1, 0);
    tick();
    b_w1 = 0;
    chk("b_zero_read", b_o1, 0);
    chk("b_zero_cnt", b_cnt, 0);

    // Dual write to register 0 still flags, but counts nothing
    b_w1 = 1; b_ad1 = 0; b_d1 = 8'h01;
    b_w2 = 1; b_ad2 = 0; b_d2 = 8'h02;
    tick();
    b_w1 = 0; b_w2 = 0;
    chk("b_zero_col", b_col, 1);
    chk("b_zero_col_cnt", b_cnt, 0);
    chk("b_zero_col_read", b_o1, 0);

    // Five single writes: 5 mod 4 = 1
    for (int i = 1; i <= 5; i++) begin
      b_w1 = 1; b_ad1 = 3'(i); b_d1 = 8'(8'h10 + i); b_ra = 3'(i);
      tick();
      chk($sformatf("b_single_reg%0d", i), b_o1, 8'h10 + i);
    end
    b_w1 = 0;
    chk("b_wrap_cnt", b_cnt, 1);

    // Forwarding check: stored value is 0 unless write-first bypass is built in
    b_w1 = 1; b_ad1 = 6; b_d1 = 8'h3C; b_ra = 6;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("b_bypass_pre_edge", b_o1, 8'h3C);
`else
    chk("b_nobypass_pre_edge", b_o1, 0);
`endif
    tick();
    b_w1 = 0;
    chk("b_reg6", b_o1, 8'h3C);
    chk("b_cnt_2", b_cnt, 2);

    b_w1 = 1; b_ad1 = 7; b_d1 = 8'h70; b_ra = 7;
    tick();
    b_w1 = 0;
    chk("b_cnt_3", b_cnt, 3);

    // All-ones plus two wraps to 1
    b_w1 = 1; b_ad1 = 1; b_d1 = 8'hA1;
    b_w2 = 1; b_ad2 = 2; b_d2 = 8'hB2;
    b_ra = 1; b_rb = 2;
    tick();
    b_w1 = 0; b_w2 = 0;
    chk("b_wrap2_cnt", b_cnt, 1);
    chk("b_wrap2_out1", b_o1, 8'hA1);
    chk("b_wrap2_out2", b_o2, 8'hB2);
    chk("b_wrap2_col", b_col, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
